// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer family.
package debounce_pkg;

  typedef enum logic [1:0] {
    StReleased   = 2'd0,
    StPressChk   = 2'd1,
    StPressed    = 2'd2,
    StReleaseChk = 2'd3
  } btn_state_e;

  localparam int unsigned TICK_DIV_5MS = 250_000;
  localparam int unsigned CLK_HZ       = 50_000_000;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-clk sample enable every TICK_DIV cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 250_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned PCNT_W = $clog2(TICK_DIV);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICK_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  logic [PCNT_W-1:0] pcnt;

  assign tick = (pcnt == PCNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_ONE;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button into a clean level plus press/release/long-press pulses,
// sampling at a divided rate via a clock enable so everything stays on clk.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned TICK_DIV       = TICK_DIV_5MS,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned LONG_SAMPLES   = 200,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned SCNT_W = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned LCNT_W = $clog2(LONG_SAMPLES + 1);

  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
  // Last sample of a check window: the next matching sample completes it.
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_SAMPLES - 1);
  localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);
  localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG_SAMPLES);
  localparam logic [LCNT_W-1:0] LCNT_PRE  = LCNT_W'(LONG_SAMPLES - 1);

  logic              p;
  logic              sync_meta;
  logic              sync_out;
  logic              s;
  logic              tick;
  btn_state_e        state;
  logic [SCNT_W-1:0] scnt;
  logic [LCNT_W-1:0] lcnt;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Polarity is normalised before the synchronizer so its reset value means "not pressed".
  assign p = ACTIVE_LOW ? ~btn_in : btn_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= p;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StReleased;
      scnt          <= '0;
      lcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      if (tick) begin
        case (state)
          StReleased: begin
            if (s) begin
              state <= StPressChk;
              scnt  <= SCNT_ONE;
            end
          end
          StPressChk: begin
            if (!s) begin
              state <= StReleased;
              scnt  <= '0;
            end else if (scnt == SCNT_LAST) begin
              state       <= StPressed;
              scnt        <= '0;
              press_pulse <= 1'b1;
              btn_level   <= 1'b1;
            end else begin
              scnt <= scnt + SCNT_ONE;
            end
          end
          StPressed: begin
            if (!s) begin
              state <= StReleaseChk;
              scnt  <= SCNT_ONE;
            end else if (lcnt != LCNT_MAX) begin
              // Saturation at LCNT_MAX is what limits long_pulse to once per press.
              lcnt <= lcnt + LCNT_ONE;
              if (lcnt == LCNT_PRE) begin
                long_pulse <= 1'b1;
              end
            end
          end
          StReleaseChk: begin
            if (s) begin
              state <= StPressed;
              scnt  <= '0;
            end else if (scnt == SCNT_LAST) begin
              state         <= StReleased;
              scnt          <= '0;
              lcnt          <= '0;
              release_pulse <= 1'b1;
              btn_level     <= 1'b0;
            end else begin
              scnt <= scnt + SCNT_ONE;
            end
          end
          default: begin
            state <= StReleased;
            scnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with TICK_DIV=4, STABLE_SAMPLES=3, LONG_SAMPLES=8.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse;

  int n_tests = 0;
  int n_fail = 0;
  int n = 0;
  int press_cnt, release_cnt, long_cnt;
  int press_at, release_at, long_at;
  int start;
  logic prev_level = 1'b0;

  always #5 clk = ~clk;

  button_debouncer #(
    .TICK_DIV      (4),
    .STABLE_SAMPLES(3),
    .LONG_SAMPLES  (8),
    .ACTIVE_LOW    (1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic clear_counts();
    press_cnt   = 0;
    release_cnt = 0;
    long_cnt    = 0;
    press_at    = -1;
    release_at  = -1;
    long_at     = -1;
  endtask

  // Hold btn_in at v for ncyc cycles, tallying pulses and checking per-cycle invariants.
  task automatic drive(input logic v, input int ncyc);
    int ones;
    btn_in = v;
    for (int i = 0; i < ncyc; i++) begin
      step();
      ones = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
      check("pulse_excl", (ones > 1) ? 1 : 0, 0);
      check("lvl_edge", int'(btn_level != prev_level), int'(press_pulse | release_pulse));
      if (press_pulse) begin
        press_cnt++;
        press_at = n;
        check("lvl_at_press", int'(btn_level), 1);
      end
      if (release_pulse) begin
        release_cnt++;
        release_at = n;
        check("lvl_at_release", int'(btn_level), 0);
      end
      if (long_pulse) begin
        long_cnt++;
        long_at = n;
      end
      prev_level = btn_level;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_out", int'({btn_level, press_pulse, release_pulse, long_pulse}), 0);
      check("tick", int'(dut.tick), ((n + 1) % 4 == 0) ? 1 : 0);
    end

    // Clean press from n=100: samples at 104,108,112 -> pulse seen 12 cycles later
    clear_counts();
    start = n;
    drive(1'b1, 20);
    check("press_cnt", press_cnt, 1);
    check("press_lat", press_at - start, 12);
    check("press_lvl", int'(btn_level), 1);
    start = n;
    drive(1'b0, 20);
    check("rel_cnt", release_cnt, 1);
    check("rel_lat", release_at - start, 12);
    check("rel_lvl", int'(btn_level), 0);

    // Bounce rejection from n=140
    clear_counts();
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 20);
    check("bounce_press", press_cnt, 0);
    check("bounce_lvl", int'(btn_level), 0);
    start = n;
    drive(1'b1, 20);
    check("post_bounce_press", press_cnt, 1);
    check("post_bounce_lat", press_at - start, 11);
    drive(1'b0, 20);
    check("post_bounce_rel", release_cnt, 1);

    // Long press from n=213
    clear_counts();
    start = n;
    drive(1'b1, 60);
    check("long_press_cnt", press_cnt, 1);
    check("long_press_lat", press_at - start, 11);
    check("long_cnt", long_cnt, 1);
    check("long_delay", long_at - press_at, 32);
    check("long_lvl", int'(btn_level), 1);

    // Release with glitch from n=273
    clear_counts();
    drive(1'b0, 4);
    drive(1'b1, 4);
    check("glitch_no_rel", release_cnt, 0);
    check("glitch_lvl", int'(btn_level), 1);
    start = n;
    drive(1'b0, 24);
    check("glitch_rel_cnt", release_cnt, 1);
    check("glitch_rel_lat", release_at - start, 11);
    check("glitch_no_long", long_cnt, 0);
    check("glitch_lvl_end", int'(btn_level), 0);

    // Reset mid-check: press from n=305 gives samples at 308,312 -> PRESS_CHK scnt=2 at n=313
    clear_counts();
    drive(1'b1, 8);
    check("pre_rst_state", int'(dut.state), 1);
    check("pre_rst_scnt", int'(dut.scnt), 2);
    reset = 1'b1;
    #1;
    check("rst_out", int'({btn_level, press_pulse, release_pulse, long_pulse}), 0);
    check("rst_state", int'(dut.state), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    prev_level = 1'b0;
    drive(1'b1, 20);
    check("rst_press_cnt", press_cnt, 1);
    check("rst_press_at", press_at, 12);
    check("rst_no_rel", release_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
